button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
// - Sits directly downstream of the button debouncer; consumes its clean, clock-synchronous level.
// - Classifies each gesture as short press, long press (with optional auto-repeat) or double click.
// - Emits one-cycle event pulses to the rest of the design.
// PARAMETERS
// - LONG_CYC    default 100_000_000  cycles held before long_press (1 s at 100 MHz); must be > 1
// - DBL_CYC     default 30_000_000   max release-to-second-press gap for double_click; must be > 1
// - REPEAT_CYC  default 20_000_000   repeat_pulse period while long-held; 0 disables repeat
// - CNT_W       default $clog2(max(LONG_CYC,DBL_CYC,REPEAT_CYC)+1)  width of the shared interval counter
// PORTS
// - clk            in   1  system clock; the only clock in this block
// - rst_n          in   1  reset, asynchronous assert, active-low
// - db_in          in   1  debounced button level; 1 = pressed; already synchronous to clk
// - press_pulse    out  1  1 cycle on every accepted press edge
// - release_pulse  out  1  1 cycle on every release edge
// - short_press    out  1  1 cycle: single press released before LONG_CYC, no second press within DBL_CYC
// - long_press     out  1  1 cycle when hold reaches LONG_CYC
// - repeat_pulse   out  1  1 cycle every REPEAT_CYC while in LONG_HELD
// - double_click   out  1  1 cycle on release of second press
// - held           out  1  level; 1 while in LONG_HELD
// BEHAVIOUR
// - Reset: state=IDLE, counter=0, db_q=0, armed=0, all outputs 0. Reset mid-gesture discards the gesture; no event is emitted.
// - Arming: armed sets on the first edge where db_in=0 is sampled. Edges are ignored while armed=0, so a button held through reset emits nothing.
// - Edge detect: db_q <= db_in; rise = db_in & ~db_q & armed; fall = ~db_in & db_q & armed.
// - All outputs are registered. An event decided at clock edge N is high for the cycle after N; latency from db_in change is 1 cycle.
// - The counter saturates and never wraps. It is cleared on every state transition.
// - States:
//   - IDLE: rise -> PRESSED, press_pulse.
//   - PRESSED: counter++.
//     - fall before counter==LONG_CYC-1 -> WAIT_SECOND, release_pulse.
//     - counter==LONG_CYC-1 with db_in=1 -> LONG_HELD, long_press.
//   - LONG_HELD: held=1; counter++.
//     - If REPEAT_CYC>0 and counter==REPEAT_CYC-1: repeat_pulse and counter=0.
//     - fall -> IDLE, release_pulse, held drops the same cycle.
//   - WAIT_SECOND: counter++.
//     - rise -> SECOND_PRESSED, press_pulse.
//     - counter==DBL_CYC-1 with no rise -> IDLE, short_press.
//   - SECOND_PRESSED: counter++.
//     - fall before LONG_CYC -> IDLE, double_click + release_pulse in the same cycle.
//     - reaches LONG_CYC-1 -> LONG_HELD, long_press; no double_click and no short_press.
// - Simultaneous events: in WAIT_SECOND, rise and timeout on the same edge -> rise wins (no short_press). In PRESSED, fall and long threshold on the same edge -> fall wins (no long_press).
// - Mutual exclusion: short_press, long_press and double_click never assert in the same cycle. Each gesture yields exactly one of them, except a gesture interrupted by reset.
// STRUCTURE
// - Package btn_event_pkg:
//   - typedef enum logic [2:0] state_t {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED}
//   - localparam default cycle counts.
// - Sub-module btn_edge_detect: db_q register, armed flag, rise/fall outputs.
// - Top: FSM, one CNT_W-bit shared counter, registered pulse outputs.
// - Parameter legality is checked at elaboration with $error.
// TESTING (LONG_CYC=20, DBL_CYC=10, REPEAT_CYC=5)
// - Short press: hold db_in=1 for 5 cycles then release -> press_pulse, release_pulse, short_press once, 10 cycles after release.
// - Long press: hold 32 cycles -> long_press at hold cycle 20; repeat_pulse at cycles 25 and 30; held=1 until release; no short_press.
// - Double click: press 3 cycles, gap 4, press 3 -> two press_pulse, double_click + release_pulse on the second release; no short_press.
// - Boundary: second press exactly at gap cycle 10 (rise/timeout collide) -> double path taken; gap of 11 -> short_press, then a new gesture.
// - Reset: db_in=1 across rst_n release -> no events until db_in goes 0 then 1. rst_n asserted mid-PRESSED -> outputs 0 immediately, no event.
// - Repeat disabled: REPEAT_CYC=0, hold 40 cycles -> single long_press, no repeat_pulse.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event decoder.
// - state_t          : gesture-classifier FSM states
// - DEF_*_CYC        : default cycle counts, sized for a 100 MHz clock
// - max3 / cnt_width : size the shared interval counter from the cycle counts
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    localparam int DEF_LONG_CYC   = 100_000_000;
    localparam int DEF_DBL_CYC    = 30_000_000;
    localparam int DEF_REPEAT_CYC = 20_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter must be able to hold the largest interval.
    function automatic int cnt_width(input int long_cyc, input int dbl_cyc, input int repeat_cyc);
        return $clog2(max3(long_cyc, dbl_cyc, repeat_cyc) + 1);
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Edge detector for the debounced button level.
// Only edges seen after the button has been observed released are reported.
// A button held through reset therefore produces no edges until it is let go.
// Ports:
// - i_clk   : system clock
// - i_rst_n : asynchronous active-low reset
// - i_db    : debounced, clock-synchronous button level (1 = pressed)
// - o_rise  : combinational, high in the cycle the level goes 0 -> 1 (when armed)
// - o_fall  : combinational, high in the cycle the level goes 1 -> 0 (when armed)
module btn_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_db,
    output logic o_rise,
    output logic o_fall
);

    logic r_db_q;
    logic r_armed;

    // Previous level plus the sticky arm flag; arming happens on the first
    // clock edge that samples the button released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_db_q <= i_db;
            if (!i_db) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = i_db & ~r_db_q & r_armed;
    assign o_fall = ~i_db & r_db_q & r_armed;

endmodule

// File: rtl/button_event_decoder.sv
// Button gesture classifier sitting behind the debouncer.
// Turns the clean button level into one-cycle event pulses: press, release,
// short press, long press (with optional auto-repeat) and double click.
// All outputs are registered; an event decided on a clock edge is visible
// for the following cycle.
// Ports:
// - clk           : system clock
// - rst_n         : asynchronous active-low reset
// - db_in         : debounced button level, 1 = pressed
// - press_pulse   : one cycle per accepted press edge
// - release_pulse : one cycle per release edge
// - short_press   : one cycle when a single short press is confirmed
// - long_press    : one cycle when a hold reaches LONG_CYC
// - repeat_pulse  : one cycle every REPEAT_CYC while long-held (0 disables)
// - double_click  : one cycle on release of the second press
// - held          : level, high while long-held
module button_event_decoder
    import btn_event_pkg::*;
#(
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int DBL_CYC    = DEF_DBL_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int CNT_W      = cnt_width(LONG_CYC, DBL_CYC, REPEAT_CYC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic held
);

    // Elaboration-time parameter legality checks.
    if (LONG_CYC <= 1) begin : g_bad_long
        $error("button_event_decoder: LONG_CYC must be greater than 1");
    end
    if (DBL_CYC <= 1) begin : g_bad_dbl
        $error("button_event_decoder: DBL_CYC must be greater than 1");
    end
    if (REPEAT_CYC < 0) begin : g_bad_repeat
        $error("button_event_decoder: REPEAT_CYC must not be negative");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
        $error("button_event_decoder: CNT_W out of range");
    end else if ((longint'(max3(LONG_CYC, DBL_CYC, REPEAT_CYC)) - 1) >= (longint'(1) << CNT_W)) begin : g_narrow_cnt
        $error("button_event_decoder: CNT_W too narrow for the configured intervals");
    end

    localparam bit              REPEAT_EN = (REPEAT_CYC > 0);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_EN ? CNT_W'(REPEAT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic w_rise;
    logic w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_press;
    logic r_release;
    logic r_short;
    logic r_long;
    logic r_repeat;
    logic r_double;
    logic r_held;

    logic w_press;
    logic w_release;
    logic w_short;
    logic w_long;
    logic w_repeat;
    logic w_double;
    logic w_held;

    btn_edge_detect u_edge (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_db    (db_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Next-state, next-counter and next-output decode. Edges take priority
    // over timeouts, so a release landing on the long threshold stays a
    // short gesture and a second press landing on the double-click timeout
    // still counts as a double click.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_double    = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end
            end

            PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = WAIT_SECOND;
                    w_release   = 1'b1;
                end else if (r_cnt == LONG_LAST && db_in) begin
                    w_state_nxt = LONG_HELD;
                    w_long      = 1'b1;
                end
            end

            LONG_HELD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (REPEAT_EN && r_cnt == REP_LAST) begin
                    w_repeat  = 1'b1;
                    w_cnt_nxt = '0;
                end
            end

            WAIT_SECOND: begin
                if (w_rise) begin
                    w_state_nxt = SECOND_PRESSED;
                    w_press     = 1'b1;
                end else if (r_cnt == DBL_LAST) begin
                    w_state_nxt = IDLE;
                    w_short     = 1'b1;
                end
            end

            SECOND_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_double    = 1'b1;
                end else if (r_cnt == LONG_LAST && db_in) begin
                    w_state_nxt = LONG_HELD;
                    w_long      = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Every interval is measured from the moment its state was entered.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end

        w_held = (w_state_nxt == LONG_HELD);
    end

    // State, shared counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_double  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_double  <= w_double;
            r_held    <= w_held;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_press   = r_short;
    assign long_press    = r_long;
    assign repeat_pulse  = r_repeat;
    assign double_click  = r_double;
    assign held          = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder.
// Two instances share stimulus: one with auto-repeat enabled, one with it
// disabled. Expected event pulses are queued with the cycle they must appear
// in and compared every cycle against what the designs produce.
module tb_button_event_decoder;

    localparam logic [5:0] EV_PRESS   = 6'b100000;
    localparam logic [5:0] EV_RELEASE = 6'b010000;
    localparam logic [5:0] EV_SHORT   = 6'b001000;
    localparam logic [5:0] EV_LONG    = 6'b000100;
    localparam logic [5:0] EV_REPEAT  = 6'b000010;
    localparam logic [5:0] EV_DOUBLE  = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } expItem_t;

    logic clk = 1'b0;
    logic rst_n;
    logic db_in;

    logic pressPulse, releasePulse, shortPress, longPress, repeatPulse, doubleClick, held;
    logic nrPress, nrRelease, nrShort, nrLong, nrRepeat, nrDouble, nrHeld;

    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    int       k;
    expItem_t expQ[$];

    button_event_decoder #(
        .LONG_CYC   (20),
        .DBL_CYC    (10),
        .REPEAT_CYC (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .db_in         (db_in),
        .press_pulse   (pressPulse),
        .release_pulse (releasePulse),
        .short_press   (shortPress),
        .long_press    (longPress),
        .repeat_pulse  (repeatPulse),
        .double_click  (doubleClick),
        .held          (held)
    );

    button_event_decoder #(
        .LONG_CYC   (20),
        .DBL_CYC    (10),
        .REPEAT_CYC (0)
    ) dutNoRepeat (
        .clk           (clk),
        .rst_n         (rst_n),
        .db_in         (db_in),
        .press_pulse   (nrPress),
        .release_pulse (nrRelease),
        .short_press   (nrShort),
        .long_press    (nrLong),
        .repeat_pulse  (nrRepeat),
        .double_click  (nrDouble),
        .held          (nrHeld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, observed, expected);
        end
    endtask

    task automatic expectEvent(input logic [5:0] mask, input int at);
        expItem_t item;
        item.cyc  = at;
        item.mask = mask;
        expQ.push_back(item);
    endtask

    // Pops the expectation due this cycle (if any) and compares both designs.
    task automatic scoreboardCheck();
        expItem_t   item;
        logic [5:0] expMask;
        logic [5:0] obsMask;
        logic [5:0] nrMask;
        expMask = '0;
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            item    = expQ.pop_front();
            expMask = item.mask;
        end
        obsMask = {pressPulse, releasePulse, shortPress, longPress, repeatPulse, doubleClick};
        nrMask  = {nrPress, nrRelease, nrShort, nrLong, nrRepeat, nrDouble};
        checkOutput("events", {2'b00, obsMask}, {2'b00, expMask});
        checkOutput("events_norepeat", {2'b00, nrMask}, {2'b00, expMask & ~EV_REPEAT});
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        db_in = level;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            scoreboardCheck();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        db_in = 1'b0;

        // Reset state
        applyStimulus(1'b0, 3);
        checkOutput("reset_held", {6'b0, held, nrHeld}, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3);

        // Short press: 5 cycles held
        $display("[TB] short press");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_RELEASE, k + 6);
        expectEvent(EV_SHORT, k + 16);
        applyStimulus(1'b1, 5);
        checkOutput("held_short", {7'b0, held}, 8'h00);
        applyStimulus(1'b0, 15);

        // Long press: 32 cycles held, two repeats
        $display("[TB] long press");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_LONG, k + 21);
        expectEvent(EV_REPEAT, k + 26);
        expectEvent(EV_REPEAT, k + 31);
        expectEvent(EV_RELEASE, k + 33);
        applyStimulus(1'b1, 20);
        checkOutput("held_before_long", {7'b0, held}, 8'h00);
        applyStimulus(1'b1, 1);
        checkOutput("held_at_long", {6'b0, held, nrHeld}, 8'h03);
        applyStimulus(1'b1, 11);
        checkOutput("held_end", {7'b0, held}, 8'h01);
        applyStimulus(1'b0, 1);
        checkOutput("held_dropped", {7'b0, held}, 8'h00);
        applyStimulus(1'b0, 14);

        // Double click: press 3, gap 4, press 3
        $display("[TB] double click");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_RELEASE, k + 4);
        expectEvent(EV_PRESS, k + 8);
        expectEvent(EV_RELEASE | EV_DOUBLE, k + 11);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 15);

        // Second press collides with the double-click timeout: press wins
        $display("[TB] gap 10 boundary");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_RELEASE, k + 4);
        expectEvent(EV_PRESS, k + 14);
        expectEvent(EV_RELEASE | EV_DOUBLE, k + 17);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 15);

        // Gap of 11: first gesture is a short press, second starts afresh
        $display("[TB] gap 11 boundary");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_RELEASE, k + 4);
        expectEvent(EV_SHORT, k + 14);
        expectEvent(EV_PRESS, k + 15);
        expectEvent(EV_RELEASE, k + 18);
        expectEvent(EV_SHORT, k + 28);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 11);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 15);

        // Long hold of 39 cycles: three repeats, none on the repeat-less design
        $display("[TB] long hold, repeat disabled instance");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_LONG, k + 21);
        expectEvent(EV_REPEAT, k + 26);
        expectEvent(EV_REPEAT, k + 31);
        expectEvent(EV_REPEAT, k + 36);
        expectEvent(EV_RELEASE, k + 40);
        applyStimulus(1'b1, 39);
        applyStimulus(1'b0, 15);

        // Button held across reset release: nothing until released and pressed again
        $display("[TB] held through reset");
        db_in = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_idle_outputs",
                    {held, nrHeld, pressPulse, releasePulse, shortPress, longPress, repeatPulse, doubleClick},
                    8'h00);
        applyStimulus(1'b1, 3);
        rst_n = 1'b1;
        applyStimulus(1'b1, 10);
        k = cyc;
        expectEvent(EV_PRESS, k + 4);
        expectEvent(EV_RELEASE, k + 7);
        expectEvent(EV_SHORT, k + 17);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 15);

        // Reset while press_pulse is high: outputs clear at once, gesture dropped
        $display("[TB] reset mid press");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        applyStimulus(1'b1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_pressed",
                    {held, nrHeld, pressPulse, releasePulse, shortPress, longPress, repeatPulse, doubleClick},
                    8'h00);
        applyStimulus(1'b1, 4);
        rst_n = 1'b1;
        applyStimulus(1'b1, 25);
        applyStimulus(1'b0, 5);

        // Recovery: a clean short press after the interrupted gesture
        $display("[TB] recovery short press");
        k = cyc;
        expectEvent(EV_PRESS, k + 1);
        expectEvent(EV_RELEASE, k + 4);
        expectEvent(EV_SHORT, k + 14);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 15);

        // Every expected event must have been consumed
        vectors++;
        assert (expQ.size() === 0) else begin
            miscompares++;
            $error("[TB] FAIL queue_drained: observed %0d pending expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
